uart_tx: RTL and testbench

// - UART frame transmitter: the transmit-side counterpart of the receive path's parity checker.
// - Accepts one parallel word per handshake and emits, one bit per CLK, the frame:

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_serializer.sv | 47 ++++
 rtl/uart_tx.sv | 101 ++++++++++
 tb/tb_uart_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared UART constants: FSM encoding, parity types, default word width
package uart_tx_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Parity type encoding is shared with the RX parity checker.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - load/shift register and bit counter for the TX data phase
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  count,
    output logic                  bit_out,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] word
);

    logic [DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;

    // word_q stays intact for parity; shreg_q always presents the next bit to send.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            word_q  <= load_data;
            shreg_q <= load_data;
            cnt_q   <= '0;
        end else begin
            if (shift) begin
                shreg_q <= shreg_q >> 1;
            end
            if (count) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_out = shreg_q[0];
    assign done    = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign word    = word_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter: start, LSB-first data, optional parity, stop
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             state;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  ser_load;
    logic                  ser_shift;
    logic                  ser_count;
    logic                  ser_bit;
    logic                  ser_done;
    logic [DATA_WIDTH-1:0] ser_word;
    logic                  par_bit;

    assign ser_load  = (state == ST_IDLE) && Data_Valid;
    assign ser_shift = (state == ST_START) || ((state == ST_DATA) && !ser_done);
    assign ser_count = (state == ST_DATA) && !ser_done;
    assign par_bit   = (par_typ_q == PAR_ODD) ? ~^ser_word : ^ser_word;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (CLK),
        .rst_n     (RST),
        .load      (ser_load),
        .load_data (P_DATA),
        .shift     (ser_shift),
        .count     (ser_count),
        .bit_out   (ser_bit),
        .done      (ser_done),
        .word      (ser_word)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        state     <= ST_START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                ST_START: begin
                    state  <= ST_DATA;
                    TX_OUT <= ser_bit;
                end
                ST_DATA: begin
                    if (!ser_done) begin
                        TX_OUT <= ser_bit;
                    end else if (par_en_q) begin
                        state  <= ST_PARITY;
                        TX_OUT <= par_bit;
                    end else begin
                        state  <= ST_STOP;
                        TX_OUT <= 1'b1;
                    end
                end
                ST_PARITY: begin
                    state  <= ST_STOP;
                    TX_OUT <= 1'b1;
                end
                ST_STOP: begin
                    // STOP never accepts: a held request is taken on the following IDLE edge.
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_checks;
    int n_pass;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // exp holds the line value of cycle i in bit i, starting with the start bit.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                              input logic [15:0] exp, input int len);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge CLK);
            check($sformatf("%s_tx%0d", tag, i), 32'(TX_OUT), 32'(exp[i]));
            check($sformatf("%s_busy%0d", tag, i), 32'(Busy), 32'd1);
        end
        @(negedge CLK);
        check($sformatf("%s_idle_tx", tag), 32'(TX_OUT), 32'd1);
        check($sformatf("%s_idle_busy", tag), 32'(Busy), 32'd0);
    endtask

    function automatic logic [7:0] b2b_word(input int c);
        return 8'(c * 37 + 5);
    endfunction

    initial begin
        logic [7:0] w;
        int         pos;
        n_checks   = 0;
        n_pass     = 0;
        RST        = 1'b0;
        P_DATA     = 8'($urandom);
        Data_Valid = 1'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        #12;
        check("rst_tx", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        check("rst_hold_tx", 32'(TX_OUT), 32'd1);
        Data_Valid = 1'b0;
        RST        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("post_rst_tx%0d", i), 32'(TX_OUT), 32'd1);
            check($sformatf("post_rst_busy%0d", i), 32'(Busy), 32'd0);
        end

        send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 16'b10101001010, 11);
        send_frame("01_odd",  8'h01, 1'b1, 1'b1, 16'b10000000010, 11);
        send_frame("01_even", 8'h01, 1'b1, 1'b0, 16'b11000000010, 11);
        send_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 16'b1111111110, 10);

        // Back-to-back: request held high, word changes every cycle, 11-cycle period without parity.
        @(negedge CLK);
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) begin
                @(negedge CLK);
                pos = (c - 1) % 11;
                w   = b2b_word(((c - 1) / 11) * 11);
                if (pos == 0) begin
                    check($sformatf("b2b_start%0d", c), 32'(TX_OUT), 32'd0);
                end else if (pos <= 8) begin
                    check($sformatf("b2b_data%0d", c), 32'(TX_OUT), 32'(w[pos-1]));
                end else begin
                    check($sformatf("b2b_stopidle%0d", c), 32'(TX_OUT), 32'd1);
                end
                check($sformatf("b2b_busy%0d", c), 32'(Busy), (pos == 10) ? 32'd0 : 32'd1);
            end
            P_DATA = b2b_word(c);
        end
        Data_Valid = 1'b0;
        repeat (12) @(negedge CLK);
        check("b2b_drain_tx", 32'(TX_OUT), 32'd1);
        check("b2b_drain_busy", 32'(Busy), 32'd0);

        // Abort 8'h3C during data bit 3 with an asynchronous reset.
        @(negedge CLK);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort_bit3", 32'(TX_OUT), 32'd1);
        check("abort_busy_before", 32'(Busy), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("abort_tx", 32'(TX_OUT), 32'd1);
        check("abort_busy", 32'(Busy), 32'd0);
        @(negedge CLK);
        check("abort_hold_busy", 32'(Busy), 32'd0);
        RST = 1'b1;
        send_frame("3c_after_rst", 8'h3C, 1'b1, 1'b0, 16'b10001111000, 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
